text_cursor_ctrl: RTL and testbench
===================================

Name: text_cursor_ctrl

Overview:
Parametrised cursor and character-buffer write controller between the UART receive byte stream and the dual-port text RAM read by the VGA text generator. It interprets printable and control bytes (CR, LF, BS, FF), generates RAM write strobes at the cursor position, and manages line wrap. It provides either hardware scroll (circular row offset plus automatic row clear) or wrap-to-top mode. It replaces the ad-hoc wx/wy cursor logic in the top level.

Parameters:
COLS, 32, characters per text row (>=2, any value, not limited to powers of two)
ROWS, 4, text rows (>=2, any value)
COL_W, $clog2(COLS), column index width
ROW_W, $clog2(ROWS), row index width
SCROLL_EN, 1, 1 = scroll at bottom row; 0 = wrap cursor to logical row 0
CLEAR_ON_RESET, 1, 1 = run full-screen clear immediately after reset release
BLANK_CHAR, 8'h20, byte written by clears and backspace

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous reset, active-low
in_data  in  8  received byte
in_valid  in  1  byte present; held until accepted
in_ready  out  1  controller can accept a byte this cycle
clr  in  1  single-cycle request for full-screen clear
wr_en  out  1  RAM write strobe
wr_row  out  ROW_W  physical RAM row for write
wr_col  out  COL_W  RAM column for write
wr_data  out  8  RAM write byte
cur_row  out  ROW_W  physical row of cursor
cur_col  out  COL_W  cursor column
top_row  out  ROW_W  physical row shown at screen top; the display path reads physical row (top_row + screen_row) mod ROWS
busy  out  1  clear in progress

Behaviour:
- Reset (reset==0 at posedge): state IDLE, lrow=0, cur_col=0, top_row=0, wr_en=0, wr_row=0, wr_col=0, wr_data=0, busy=0, in_ready=0.
- Cycle after release: if CLEAR_ON_RESET, enter CLEAR_ALL; otherwise enter IDLE.
- lrow is the logical cursor row. cur_row = (top_row + lrow) mod ROWS, computed by compare-and-subtract. No modulo operator; no power-of-two assumption.
- States:
  - IDLE: in_ready=1. Handshake is in_valid & in_ready; the byte is consumed in the same cycle.
  - CLEAR_ROW: in_ready=0. Write BLANK_CHAR to columns 0..COLS-1 of one row, one column per cycle. Return to IDLE.
  - CLEAR_ALL: in_ready=0. Write BLANK_CHAR to all ROWS*COLS cells in row-major order from physical (0,0). Then set lrow=0, cur_col=0, top_row=0 and return to IDLE.
- busy=1 exactly while in CLEAR_ROW or CLEAR_ALL.
- All write outputs are registered. wr_en rises the cycle after acceptance or after a clear step. Each write is a 1-cycle pulse per accepted printable byte.
- Byte decode on acceptance:
  - 0x20..0x7E: write the byte at (cur_row, cur_col). If cur_col<COLS-1, cur_col++. Otherwise perform a line advance.
  - 0x0D (CR): cur_col=0; no write.
  - 0x0A (LF): line advance; no write. CR LF therefore yields exactly one new line.
  - 0x08 (BS): if cur_col>0, cur_col-- and write BLANK_CHAR at the new position. At cur_col==0: no action.
  - 0x0C (FF): enter CLEAR_ALL.
  - Any other byte: consumed, no write, cursor unchanged.
- Line advance sets cur_col=0, then:
  - lrow<ROWS-1: lrow++.
  - lrow==ROWS-1 and SCROLL_EN=1: top_row = (top_row+1) mod ROWS; lrow stays ROWS-1. Enter CLEAR_ROW on the new cur_row, which is the old top_row.
  - lrow==ROWS-1 and SCROLL_EN=0: lrow=0; no clear.
- A printable byte in the last column with scroll writes its character first, then starts the row clear the next cycle.
- clr is sampled only in IDLE. If clr and in_valid occur together, clr wins and the byte is not accepted (in_ready drops the next cycle). clr during a clear is ignored.
- Reset mid-clear aborts immediately to reset values. Partial RAM contents are acceptable.
- Wrap arithmetic: column and row counters compare against COLS-1 and ROWS-1 explicitly. Counters never take values >= COLS or >= ROWS.

Decomposition:
- Shared package text_pkg: ASCII constants CR=8'h0D, LF=8'h0A, BS=8'h08, FF=8'h0C, PRINT_LO=8'h20, PRINT_HI=8'h7E, and the state enum {IDLE, CLEAR_ROW, CLEAR_ALL}.
- One sub-module: mod_add_wrap (parametrised N-bit, modulus M), giving (a+b) mod M for a,b<M by compare-and-subtract. It is used for cur_row and the top_row increment.

Test Plan:
- Defaults with CLEAR_ON_RESET=1 -> release reset -> 128 consecutive wr_en pulses of 8'h20 with busy=1, then in_ready=1 and cursor (0,0).
- Send "AB" -> writes (0,0)=0x41 and (0,1)=0x42, each one cycle after acceptance; cur_col=2. Then send 0x08 -> write 0x20 at (0,1); cur_col=1.
- Send 32 printable bytes starting at lrow=3, SCROLL_EN=1 -> 32nd written at (3,31); top_row 0->1; 32 blank writes to physical row 0 with in_ready=0; cursor at physical row 0, col 0.
- Same sequence with SCROLL_EN=0 -> cursor wraps to lrow 0, col 0; no clear writes; top_row stays 0.
- Send CR then LF from (1,5) -> cursor (2,0); no wr_en. Assert clr together with in_valid=1 (byte 0x41) -> no 0x41 write; CLEAR_ALL runs; 0x41 accepted after busy falls and written at (0,0).
- Drive reset low midway through CLEAR_ALL -> next cycle wr_en=0, busy=0, all cursor outputs 0.

Source files
------------

// File: rtl/text_pkg.sv
// text_pkg: ASCII control codes and state encoding
// shared by the text cursor controller and its helpers.
package text_pkg;

  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] FF       = 8'h0C;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_ROW,
    CLEAR_ALL
  } state_t;

  function automatic logic is_print(
    input logic [7:0] b
  );
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/mod_add_wrap.sv
// mod_add_wrap: y = (a + b) mod M for a, b < M,
// by compare-and-subtract. Ports: a, b in; y out.
module mod_add_wrap #(
  parameter int N = 2,
  parameter int M = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  localparam logic [N:0] MOD = M[N:0];

  logic [N:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= MOD) y = N'(sum - MOD);
    else            y = sum[N-1:0];
  end

endmodule

// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl: turns the received byte stream into
// text RAM writes, tracks the cursor and scrolls or wraps.
// Ports: clk, reset (sync, low); in_data/in_valid/in_ready
// byte handshake; clr full clear request; wr_en/wr_row/
// wr_col/wr_data RAM write; cur_row/cur_col cursor;
// top_row screen origin row; busy while clearing.
module text_cursor_ctrl
  import text_pkg::*;
#(
  parameter int         COLS           = 32,
  parameter int         ROWS           = 4,
  parameter int         COL_W          = $clog2(COLS),
  parameter int         ROW_W          = $clog2(ROWS),
  parameter bit         SCROLL_EN      = 1'b1,
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] BLANK_CHAR     = 8'h20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic [ROW_W-1:0] top_row,
  output logic             busy
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  state_t           state, state_n;
  logic             boot;
  logic             drain, drain_n;
  logic [ROW_W-1:0] lrow, lrow_n;
  logic [ROW_W-1:0] top_n, top_inc;
  logic [ROW_W-1:0] crow, crow_n;
  logic [COL_W-1:0] col_n;
  logic [COL_W-1:0] ccol, ccol_n;
  logic             we_n;
  logic [ROW_W-1:0] wrow_n;
  logic [COL_W-1:0] wcol_n;
  logic [7:0]       wdat_n;
  logic             adv;

  mod_add_wrap #(.N(ROW_W), .M(ROWS)) u_cur (
    .a(top_row),
    .b(lrow),
    .y(cur_row)
  );

  mod_add_wrap #(.N(ROW_W), .M(ROWS)) u_top (
    .a(top_row),
    .b(ROW_ONE),
    .y(top_inc)
  );

  // boot marks the first cycle after reset release
  assign busy     = (state != IDLE);
  assign in_ready = (state == IDLE) && !boot;

  always_comb begin
    state_n = state;
    drain_n = drain;
    lrow_n  = lrow;
    col_n   = cur_col;
    top_n   = top_row;
    crow_n  = crow;
    ccol_n  = ccol;
    we_n    = 1'b0;
    wrow_n  = wr_row;
    wcol_n  = wr_col;
    wdat_n  = wr_data;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        crow_n  = '0;
        ccol_n  = '0;
        drain_n = 1'b0;
        if (boot) begin
          if (CLEAR_ON_RESET) state_n = CLEAR_ALL;
        end else if (clr) begin
          state_n = CLEAR_ALL;
        end else if (in_valid) begin
          unique case (1'b1)
            is_print(in_data): begin
              we_n   = 1'b1;
              wrow_n = cur_row;
              wcol_n = cur_col;
              wdat_n = in_data;
              if (cur_col != COL_MAX)
                col_n = cur_col + 1'b1;
              else
                adv = 1'b1;
            end
            (in_data == CR): col_n = '0;
            (in_data == LF): adv = 1'b1;
            (in_data == BS): begin
              if (cur_col != '0) begin
                col_n  = cur_col - 1'b1;
                we_n   = 1'b1;
                wrow_n = cur_row;
                wcol_n = cur_col - 1'b1;
                wdat_n = BLANK_CHAR;
              end
            end
            (in_data == FF): state_n = CLEAR_ALL;
            default: ;
          endcase
          if (adv) begin
            col_n = '0;
            if (lrow != ROW_MAX) begin
              lrow_n = lrow + 1'b1;
            end else if (SCROLL_EN) begin
              // new cursor row is the old top row
              top_n   = top_inc;
              state_n = CLEAR_ROW;
            end else begin
              lrow_n = '0;
            end
          end
        end
      end
      CLEAR_ROW: begin
        // extra drain cycle keeps busy over the last write
        if (drain) begin
          state_n = IDLE;
        end else begin
          we_n   = 1'b1;
          wrow_n = cur_row;
          wcol_n = ccol;
          wdat_n = BLANK_CHAR;
          if (ccol == COL_MAX) drain_n = 1'b1;
          else                 ccol_n  = ccol + 1'b1;
        end
      end
      CLEAR_ALL: begin
        if (drain) begin
          state_n = IDLE;
          lrow_n  = '0;
          col_n   = '0;
          top_n   = '0;
        end else begin
          we_n   = 1'b1;
          wrow_n = crow;
          wcol_n = ccol;
          wdat_n = BLANK_CHAR;
          if (ccol == COL_MAX) begin
            ccol_n = '0;
            if (crow == ROW_MAX) drain_n = 1'b1;
            else                 crow_n  = crow + 1'b1;
          end else begin
            ccol_n = ccol + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      boot    <= 1'b1;
      drain   <= 1'b0;
      lrow    <= '0;
      cur_col <= '0;
      top_row <= '0;
      crow    <= '0;
      ccol    <= '0;
      wr_en   <= 1'b0;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      boot    <= 1'b0;
      drain   <= drain_n;
      lrow    <= lrow_n;
      cur_col <= col_n;
      top_row <= top_n;
      crow    <= crow_n;
      ccol    <= ccol_n;
      wr_en   <= we_n;
      wr_row  <= wrow_n;
      wr_col  <= wcol_n;
      wr_data <= wdat_n;
    end
  end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// tb_text_cursor_ctrl: scroll and wrap instances driven
// by directed and random bytes, checked against a model.
module tb_text_cursor_ctrl;

  localparam int COLS  = 32;
  localparam int ROWS  = 4;
  localparam int COL_W = 5;
  localparam int ROW_W = 2;
  localparam int BLANK = 32;
  localparam int WAIT  = 2000;

  typedef struct {
    bit boot;
    bit busy;
    bit all;
    int idx;
    int n;
    int crow;
    int lrow;
    int col;
    int top;
    bit we;
    int wrow;
    int wcol;
    int wdat;
  } ms_t;

  typedef struct {
    int r;
    int c;
    int d;
  } wr_t;

  logic             clk;
  logic             reset;
  logic             vld     [2];
  logic [7:0]       dat     [2];
  logic             cl      [2];
  logic             in_ready[2];
  logic             wr_en   [2];
  logic [ROW_W-1:0] wr_row  [2];
  logic [COL_W-1:0] wr_col  [2];
  logic [7:0]       wr_data [2];
  logic [ROW_W-1:0] cur_row [2];
  logic [COL_W-1:0] cur_col [2];
  logic [ROW_W-1:0] top_row [2];
  logic             busy    [2];

  ms_t m [2];
  wr_t wlog0[$];
  wr_t wlog1[$];
  int  n_chk;
  int  n_fail;
  bit  chk_en;

  text_cursor_ctrl #(.SCROLL_EN(1'b1)) u_scroll (
    .clk     (clk),
    .reset   (reset),
    .in_data (dat[0]),
    .in_valid(vld[0]),
    .in_ready(in_ready[0]),
    .clr     (cl[0]),
    .wr_en   (wr_en[0]),
    .wr_row  (wr_row[0]),
    .wr_col  (wr_col[0]),
    .wr_data (wr_data[0]),
    .cur_row (cur_row[0]),
    .cur_col (cur_col[0]),
    .top_row (top_row[0]),
    .busy    (busy[0])
  );

  text_cursor_ctrl #(.SCROLL_EN(1'b0)) u_wrap (
    .clk     (clk),
    .reset   (reset),
    .in_data (dat[1]),
    .in_valid(vld[1]),
    .in_ready(in_ready[1]),
    .clr     (cl[1]),
    .wr_en   (wr_en[1]),
    .wr_row  (wr_row[1]),
    .wr_col  (wr_col[1]),
    .wr_data (wr_data[1]),
    .cur_row (cur_row[1]),
    .cur_col (cur_col[1]),
    .top_row (top_row[1]),
    .busy    (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: screen semantics with plain arithmetic.
  // A clear of n cells emits n writes, then one more
  // busy cycle before bytes are accepted again.
  function automatic ms_t step(
    ms_t s, bit scroll, logic rst,
    logic v, logic [7:0] d, logic c
  );
    ms_t t;
    int  row;
    bit  adv;
    t    = s;
    t.we = 1'b0;
    adv  = 1'b0;
    if (!rst) begin
      t      = '{default: 0};
      t.boot = 1'b1;
      return t;
    end
    if (s.boot) begin
      t.boot = 1'b0;
      t.busy = 1'b1;
      t.all  = 1'b1;
      t.idx  = 0;
      t.n    = ROWS * COLS;
      return t;
    end
    if (s.busy) begin
      if (s.idx < s.n) begin
        t.we   = 1'b1;
        t.wrow = s.all ? s.idx / COLS : s.crow;
        t.wcol = s.all ? s.idx % COLS : s.idx;
        t.wdat = BLANK;
        t.idx  = s.idx + 1;
      end else begin
        t.busy = 1'b0;
        if (s.all) begin
          t.lrow = 0;
          t.col  = 0;
          t.top  = 0;
        end
      end
      return t;
    end
    if (c || (v && d == 8'h0C)) begin
      t.busy = 1'b1;
      t.all  = 1'b1;
      t.idx  = 0;
      t.n    = ROWS * COLS;
      return t;
    end
    if (!v) return t;
    row = (s.top + s.lrow) % ROWS;
    if (d >= 8'h20 && d <= 8'h7E) begin
      t.we   = 1'b1;
      t.wrow = row;
      t.wcol = s.col;
      t.wdat = int'(d);
      if (s.col < COLS - 1) t.col = s.col + 1;
      else adv = 1'b1;
    end else if (d == 8'h0D) begin
      t.col = 0;
    end else if (d == 8'h0A) begin
      adv = 1'b1;
    end else if (d == 8'h08 && s.col > 0) begin
      t.col  = s.col - 1;
      t.we   = 1'b1;
      t.wrow = row;
      t.wcol = s.col - 1;
      t.wdat = BLANK;
    end
    if (adv) begin
      t.col = 0;
      if (s.lrow < ROWS - 1) begin
        t.lrow = s.lrow + 1;
      end else if (scroll) begin
        t.top  = (s.top + 1) % ROWS;
        t.busy = 1'b1;
        t.all  = 1'b0;
        t.idx  = 0;
        t.n    = COLS;
        t.crow = (t.top + t.lrow) % ROWS;
      end else begin
        t.lrow = 0;
      end
    end
    return t;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      m[k] <= step(m[k], k == 0, reset,
                   vld[k], dat[k], cl[k]);
  end

  task automatic check(string nm, int k,
                       int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d want %0d",
               nm, k, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("in_ready", k, int'(in_ready[k]),
              int'(!m[k].boot && !m[k].busy));
        check("busy", k, int'(busy[k]), int'(m[k].busy));
        check("wr_en", k, int'(wr_en[k]), int'(m[k].we));
        if (wr_en[k] && m[k].we) begin
          check("wr_row", k, int'(wr_row[k]), m[k].wrow);
          check("wr_col", k, int'(wr_col[k]), m[k].wcol);
          check("wr_data", k, int'(wr_data[k]), m[k].wdat);
        end
        check("cur_row", k, int'(cur_row[k]),
              (m[k].top + m[k].lrow) % ROWS);
        check("cur_col", k, int'(cur_col[k]), m[k].col);
        check("top_row", k, int'(top_row[k]), m[k].top);
      end
    end
  end

  always @(negedge clk) begin
    if (wr_en[0])
      wlog0.push_back('{int'(wr_row[0]), int'(wr_col[0]),
                        int'(wr_data[0])});
    if (wr_en[1])
      wlog1.push_back('{int'(wr_row[1]), int'(wr_col[1]),
                        int'(wr_data[1])});
  end

  task automatic wait_ready(int k);
    int n;
    n = 0;
    while (!in_ready[k] && n < WAIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout dut%0d: in_ready got 0 want 1",
               k);
    end
  endtask

  task automatic send(int k, logic [7:0] b);
    vld[k] = 1'b1;
    dat[k] = b;
    wait_ready(k);
    @(negedge clk);
    vld[k] = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic log_len(string nm, int k, int exp);
    if (k == 0) check(nm, k, wlog0.size(), exp);
    else        check(nm, k, wlog1.size(), exp);
  endtask

  task automatic chk_w(int k, int i, int r, int c, int d);
    wr_t w;
    int  sz;
    sz = (k == 0) ? wlog0.size() : wlog1.size();
    if (i >= sz) begin
      check("log entry", k, sz, i + 1);
      return;
    end
    if (k == 0) w = wlog0[i];
    else        w = wlog1[i];
    check("log row", k, w.r, r);
    check("log col", k, w.c, c);
    check("log data", k, w.d, d);
  endtask

  task automatic chk_zero(int k);
    check("rst wr_en", k, int'(wr_en[k]), 0);
    check("rst busy", k, int'(busy[k]), 0);
    check("rst in_ready", k, int'(in_ready[k]), 0);
    check("rst cur_row", k, int'(cur_row[k]), 0);
    check("rst cur_col", k, int'(cur_col[k]), 0);
    check("rst top_row", k, int'(top_row[k]), 0);
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 8'($urandom_range(32, 126));
    if (r < 78) return 8'h0D;
    if (r < 88) return 8'h0A;
    if (r < 95) return 8'h08;
    if (r < 96) return 8'h0C;
    return 8'($urandom_range(127, 255));
  endfunction

  initial begin
    int blanks;
    n_chk  = 0;
    n_fail = 0;
    chk_en = 1'b0;
    reset  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0;
      dat[k] = 8'h00;
      cl[k]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk_zero(0);
    chk_zero(1);
    check("rst wr_data", 0, int'(wr_data[0]), 0);

    // power-up clear
    reset = 1'b1;
    wait_ready(0);
    wait_ready(1);
    settle();
    log_len("boot clear len", 0, 128);
    log_len("boot clear len", 1, 128);
    blanks = 0;
    foreach (wlog0[i]) if (wlog0[i].d == BLANK) blanks++;
    check("boot blanks", 0, blanks, 128);
    chk_w(0, 0, 0, 0, BLANK);
    chk_w(0, 127, 3, 31, BLANK);
    check("boot cur_col", 0, int'(cur_col[0]), 0);
    wlog0.delete();
    wlog1.delete();

    // "AB" then backspace
    send(0, 8'h41);
    send(0, 8'h42);
    settle();
    chk_w(0, 0, 0, 0, 8'h41);
    chk_w(0, 1, 0, 1, 8'h42);
    check("AB cur_col", 0, int'(cur_col[0]), 2);
    send(0, 8'h08);
    settle();
    chk_w(0, 2, 0, 1, BLANK);
    check("BS cur_col", 0, int'(cur_col[0]), 1);

    // fill last row: scroll vs wrap
    for (int k = 0; k < 2; k++) begin
      send(k, 8'h0D);
      repeat (3) send(k, 8'h0A);
      settle();
      check("lrow3 cur_row", k, int'(cur_row[k]), 3);
    end
    wlog0.delete();
    wlog1.delete();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < COLS; i++)
        send(k, 8'h61 + 8'(i % 26));
      wait_ready(k);
    end
    settle();
    log_len("scroll len", 0, 64);
    chk_w(0, 31, 3, 31, 8'h61 + 31 % 26);
    chk_w(0, 32, 0, 0, BLANK);
    chk_w(0, 63, 0, 31, BLANK);
    check("scroll top_row", 0, int'(top_row[0]), 1);
    check("scroll cur_row", 0, int'(cur_row[0]), 0);
    check("scroll cur_col", 0, int'(cur_col[0]), 0);
    log_len("wrap len", 1, 32);
    chk_w(1, 31, 3, 31, 8'h61 + 31 % 26);
    check("wrap top_row", 1, int'(top_row[1]), 0);
    check("wrap cur_row", 1, int'(cur_row[1]), 0);
    check("wrap cur_col", 1, int'(cur_col[1]), 0);

    // CR LF from (1,5)
    send(1, 8'h0A);
    for (int i = 0; i < 5; i++) send(1, 8'h30);
    settle();
    check("pre crlf row", 1, int'(cur_row[1]), 1);
    check("pre crlf col", 1, int'(cur_col[1]), 5);
    wlog1.delete();
    send(1, 8'h0D);
    send(1, 8'h0A);
    settle();
    log_len("crlf no write", 1, 0);
    check("crlf cur_row", 1, int'(cur_row[1]), 2);
    check("crlf cur_col", 1, int'(cur_col[1]), 0);

    // clr beats a simultaneous byte
    vld[1] = 1'b1;
    dat[1] = 8'h41;
    cl[1]  = 1'b1;
    @(negedge clk);
    cl[1]  = 1'b0;
    check("clr drops ready", 1, int'(in_ready[1]), 0);
    wait_ready(1);
    @(negedge clk);
    vld[1] = 1'b0;
    settle();
    log_len("clr len", 1, 129);
    chk_w(1, 0, 0, 0, BLANK);
    chk_w(1, 127, 3, 31, BLANK);
    chk_w(1, 128, 0, 0, 8'h41);
    check("clr cur_col", 1, int'(cur_col[1]), 1);

    // reset in the middle of a full clear
    send(0, 8'h0C);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    reset = 1'b1;
    wait_ready(0);
    wait_ready(1);

    // random traffic
    for (int k = 0; k < 2; k++) begin
      repeat (300) begin
        if ($urandom_range(0, 59) == 0) begin
          cl[k] = 1'b1;
          @(negedge clk);
          cl[k] = 1'b0;
        end else begin
          send(k, pick());
        end
      end
      wait_ready(k);
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
